// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared definitions for the PWM generator family: the default dead-time
// counter width and the gate-driver state encodings.
// No ports (package).
// -----------------------------------------------------------------------------
package pwm_pkg;

    // Default width of the dead-time count.
    localparam int DT_W_DEFAULT = 16;

    // Fixed state encodings, shared so other blocks and debug tools agree.
    localparam logic [2:0] ENC_OFF     = 3'd0;
    localparam logic [2:0] ENC_DT_TO_L = 3'd1;
    localparam logic [2:0] ENC_LOW_ON  = 3'd2;
    localparam logic [2:0] ENC_DT_TO_H = 3'd3;
    localparam logic [2:0] ENC_HIGH_ON = 3'd4;
    localparam logic [2:0] ENC_FAULT   = 3'd5;

    typedef enum logic [2:0] {
        ST_OFF     = ENC_OFF,
        ST_DT_TO_L = ENC_DT_TO_L,
        ST_LOW_ON  = ENC_LOW_ON,
        ST_DT_TO_H = ENC_DT_TO_H,
        ST_HIGH_ON = ENC_HIGH_ON,
        ST_FAULT   = ENC_FAULT
    } pwm_state_e;

endpackage

// File: rtl/pwm_dt_counter.sv
// -----------------------------------------------------------------------------
// pwm_dt_counter
// Load/decrement counter timing one dead band. Loaded with the band length on
// band entry, counts down to zero and then holds.
// Ports:
//   clk      - clock, posedge
//   rst      - synchronous active-high reset (count cleared to 0)
//   load     - load load_val this edge (wins over decrement)
//   load_val - band length in cycles (caller guarantees >= 1)
//   done     - count equals 1: the current cycle is the last of the band
// -----------------------------------------------------------------------------
module pwm_dt_counter
    import pwm_pkg::*;
#(
    parameter int DT_W = DT_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [DT_W-1:0] load_val,
    output logic            done
);

    localparam logic [DT_W-1:0] CNT_ONE  = {{(DT_W-1){1'b0}}, 1'b1};
    localparam logic [DT_W-1:0] CNT_ZERO = {DT_W{1'b0}};

    logic [DT_W-1:0] r_cnt;

    // Count register: load on band entry, otherwise decrement down to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= CNT_ZERO;
        end else if (load) begin
            r_cnt <= load_val;
        end else if (r_cnt != CNT_ZERO) begin
            r_cnt <= r_cnt - CNT_ONE;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign done = (r_cnt == CNT_ONE);

endmodule

// File: rtl/pwm_deadtime.sv
// -----------------------------------------------------------------------------
// pwm_deadtime
// Complementary gate driver with dead-time insertion and latched fault.
// Ports:
//   clk           - clock, posedge
//   rst           - synchronous active-high reset, overrides everything
//   en            - output-stage enable; 0 forces both gates off
//   pwm_in        - PWM demand from the upstream generator
//   dead_time     - dead band length in clk cycles (0 treated as 1)
//   fault         - external fault request, highest priority
//   fault_clr     - leaves FAULT when asserted while fault is low
//   pwm_h, pwm_l  - registered high/low side gate drives
//   fault_latched - registered, high while in FAULT
// -----------------------------------------------------------------------------
module pwm_deadtime
    import pwm_pkg::*;
#(
    parameter int DT_W = DT_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            pwm_in,
    input  logic [DT_W-1:0] dead_time,
    input  logic            fault,
    input  logic            fault_clr,
    output logic            pwm_h,
    output logic            pwm_l,
    output logic            fault_latched
);

    localparam logic [DT_W-1:0] DT_ONE  = {{(DT_W-1){1'b0}}, 1'b1};
    localparam logic [DT_W-1:0] DT_ZERO = {DT_W{1'b0}};

    pwm_state_e      r_state;
    pwm_state_e      w_next;
    logic            r_pwm_q;
    logic            r_pwm_h;
    logic            r_pwm_l;
    logic            r_fault_latched;
    logic            w_load;
    logic            w_done;
    logic [DT_W-1:0] w_load_val;

    // A zero dead time still needs one both-off cycle between sides.
    assign w_load_val = (dead_time == DT_ZERO) ? DT_ONE : dead_time;

    // Load only on entry, so dead_time changes mid-band are ignored.
    assign w_load = ((w_next == ST_DT_TO_H) && (r_state != ST_DT_TO_H)) ||
                    ((w_next == ST_DT_TO_L) && (r_state != ST_DT_TO_L));

    pwm_dt_counter #(
        .DT_W (DT_W)
    ) u_dt_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .load_val (w_load_val),
        .done     (w_done)
    );

    // Next-state logic: fault beats en, en beats PWM sequencing.
    always_comb begin
        w_next = r_state;
        if (fault) begin
            w_next = ST_FAULT;
        end else if (r_state == ST_FAULT) begin
            if (fault_clr) begin
                w_next = ST_OFF;
            end else begin
                w_next = ST_FAULT;
            end
        end else if (!en) begin
            w_next = ST_OFF;
        end else begin
            case (r_state)
                ST_OFF:     w_next = ST_DT_TO_L;
                ST_LOW_ON:  w_next = r_pwm_q ? ST_DT_TO_H : ST_LOW_ON;
                ST_HIGH_ON: w_next = r_pwm_q ? ST_HIGH_ON : ST_DT_TO_L;
                // Demand reverting mid-band returns to the side that is still
                // safe: the other switch was never turned on.
                ST_DT_TO_H: begin
                    if (!r_pwm_q) begin
                        w_next = ST_LOW_ON;
                    end else if (w_done) begin
                        w_next = ST_HIGH_ON;
                    end else begin
                        w_next = ST_DT_TO_H;
                    end
                end
                ST_DT_TO_L: begin
                    if (r_pwm_q) begin
                        w_next = ST_HIGH_ON;
                    end else if (w_done) begin
                        w_next = ST_LOW_ON;
                    end else begin
                        w_next = ST_DT_TO_L;
                    end
                end
                default:    w_next = ST_OFF;
            endcase
        end
    end

    // State, input sample and outputs decoded from next state, so outputs
    // change on the same edge as the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_OFF;
            r_pwm_q         <= 1'b0;
            r_pwm_h         <= 1'b0;
            r_pwm_l         <= 1'b0;
            r_fault_latched <= 1'b0;
        end else begin
            r_state         <= w_next;
            r_pwm_q         <= pwm_in;
            r_pwm_h         <= (w_next == ST_HIGH_ON);
            r_pwm_l         <= (w_next == ST_LOW_ON);
            r_fault_latched <= (w_next == ST_FAULT);
        end
    end

    assign pwm_h         = r_pwm_h;
    assign pwm_l         = r_pwm_l;
    assign fault_latched = r_fault_latched;

endmodule

// File: tb/tb_pwm_deadtime.sv
// -----------------------------------------------------------------------------
// tb_pwm_deadtime
// Directed vector table for the dead-band corner cases, then randomized
// stimulus compared each cycle against a behavioural reference model.
// -----------------------------------------------------------------------------
module tb_pwm_deadtime;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        pwm_in = 1'b0;
    logic [15:0] dead_time = 16'd0;
    logic        fault = 1'b0;
    logic        fault_clr = 1'b0;
    logic        pwm_h;
    logic        pwm_l;
    logic        fault_latched;

    int checks = 0;
    int errors = 0;

    pwm_deadtime #(.DT_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .pwm_in        (pwm_in),
        .dead_time     (dead_time),
        .fault         (fault),
        .fault_clr     (fault_clr),
        .pwm_h         (pwm_h),
        .pwm_l         (pwm_l),
        .fault_latched (fault_latched)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        en;
        logic        pin;
        logic [15:0] dt;
        logic        f;
        logic        clr;
        logic        eh;
        logic        el;
        logic        ef;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic r, input logic e, input logic p,
                               input logic [15:0] d, input logic f, input logic c,
                               input logic eh, input logic el, input logic ef);
        vec_t x;
        x.rst = r; x.en = e; x.pin = p; x.dt = d; x.f = f; x.clr = c;
        x.eh = eh; x.el = el; x.ef = ef;
        return x;
    endfunction

    // Reference model: tracks whether the stage is running, which side it
    // is heading to / holding, and how many dead cycles remain.
    logic m_fault, m_run, m_target, m_q;
    int   m_rem;

    task automatic model_step(input logic r, input logic e, input logic p,
                              input logic f, input logic c, input int dt);
        int n;
        n = (dt == 0) ? 1 : dt;
        if (r) begin
            m_fault = 1'b0; m_run = 1'b0; m_target = 1'b0; m_rem = 0; m_q = 1'b0;
        end else begin
            if (f) begin
                m_fault = 1'b1; m_run = 1'b0;
            end else if (m_fault) begin
                if (c) m_fault = 1'b0;
            end else if (!e) begin
                m_run = 1'b0;
            end else if (!m_run) begin
                m_run = 1'b1; m_target = 1'b0; m_rem = n;
            end else if (m_q != m_target) begin
                // conducting: start a band; mid-band: fall back with no band
                m_target = m_q;
                m_rem    = (m_rem == 0) ? n : 0;
            end else if (m_rem > 0) begin
                m_rem = m_rem - 1;
            end
            m_q = p;
        end
    endtask

    task automatic check(input string name, input logic eh, input logic el, input logic ef);
        checks++;
        if (pwm_h !== eh || pwm_l !== el || fault_latched !== ef) begin
            errors++;
            $display("FAIL %s: got h=%b l=%b fl=%b, expected h=%b l=%b fl=%b",
                     name, pwm_h, pwm_l, fault_latched, eh, el, ef);
        end
        checks++;
        if (pwm_h === 1'b1 && pwm_l === 1'b1) begin
            errors++;
            $display("FAIL %s_shoot_through: got h=%b l=%b, expected never both 1",
                     name, pwm_h, pwm_l);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic p,
                         input logic [15:0] d, input logic f, input logic c);
        rst = r; en = e; pwm_in = p; dead_time = d; fault = f; fault_clr = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // rst en pin dt f clr -> h l fl
        // power-up: 5-cycle band then low side
        tbl.push_back(v(1, 0, 0, 16'd5, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 16'd5, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 16'd5, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 16'd5, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 16'd5, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 16'd5, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 16'd5, 0, 0, 0, 1, 0));
        // dt=3 rise then fall
        tbl.push_back(v(0, 1, 1, 16'd3, 0, 0, 0, 1, 0));
        tbl.push_back(v(0, 1, 1, 16'd3, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 1, 16'd3, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 1, 16'd3, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 1, 16'd3, 0, 0, 1, 0, 0));
        tbl.push_back(v(0, 1, 0, 16'd3, 0, 0, 1, 0, 0));
        tbl.push_back(v(0, 1, 0, 16'd3, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 16'd3, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 16'd3, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 16'd3, 0, 0, 0, 1, 0));
        // dt=0 gives exactly one both-low cycle
        tbl.push_back(v(0, 1, 1, 16'd0, 0, 0, 0, 1, 0));
        tbl.push_back(v(0, 1, 1, 16'd0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 1, 16'd0, 0, 0, 1, 0, 0));
        tbl.push_back(v(0, 1, 0, 16'd0, 0, 0, 1, 0, 0));
        tbl.push_back(v(0, 1, 0, 16'd0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 16'd0, 0, 0, 0, 1, 0));
        // dt=8, 4-cycle pulse is swallowed, low side returns
        tbl.push_back(v(0, 1, 1, 16'd8, 0, 0, 0, 1, 0));
        tbl.push_back(v(0, 1, 1, 16'd8, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 1, 16'd8, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 1, 16'd8, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 16'd8, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 16'd8, 0, 0, 0, 1, 0));
        tbl.push_back(v(0, 1, 0, 16'd8, 0, 0, 0, 1, 0));
        // reach HIGH_ON with dt=2, then fault handling
        tbl.push_back(v(0, 1, 1, 16'd2, 0, 0, 0, 1, 0));
        tbl.push_back(v(0, 1, 1, 16'd2, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 1, 16'd2, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 1, 16'd2, 0, 0, 1, 0, 0));
        tbl.push_back(v(0, 1, 1, 16'd2, 1, 0, 0, 0, 1));
        tbl.push_back(v(0, 1, 1, 16'd2, 1, 1, 0, 0, 1));
        tbl.push_back(v(0, 1, 1, 16'd2, 0, 0, 0, 0, 1));
        tbl.push_back(v(0, 1, 1, 16'd2, 0, 1, 0, 0, 0));
        // restart from OFF with pwm_q high: band aborts straight to high side
        tbl.push_back(v(0, 1, 1, 16'd2, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 1, 16'd2, 0, 0, 1, 0, 0));
        // en drop, then reset overriding an active fault
        tbl.push_back(v(0, 0, 1, 16'd2, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 16'd2, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 1, 0, 16'd2, 1, 0, 0, 0, 1));
        tbl.push_back(v(1, 1, 0, 16'd2, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 0, 0, 16'd2, 0, 0, 0, 0, 0));

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].en, tbl[i].pin, tbl[i].dt, tbl[i].f, tbl[i].clr);
            check($sformatf("vec%0d", i), tbl[i].eh, tbl[i].el, tbl[i].ef);
        end

        // Randomized phase; first cycle resets DUT and model together.
        begin
            logic r, e, p, f, c;
            logic [15:0] d;
            p = 1'b0;
            d = 16'd3;
            for (int cyc = 0; cyc < 20000; cyc++) begin
                r = (cyc == 0) || ($urandom_range(0, 500) == 0);
                e = ($urandom_range(0, 40) != 0);
                f = ($urandom_range(0, 150) == 0);
                c = ($urandom_range(0, 7) == 0);
                if ($urandom_range(0, 5) == 0) p = ~p;
                if ($urandom_range(0, 15) == 0) d = 16'($urandom_range(0, 6));
                drive(r, e, p, d, f, c);
                model_step(r, e, p, f, c, int'(d));
                check($sformatf("rand%0d", cyc),
                      m_run && (m_rem == 0) && m_target,
                      m_run && (m_rem == 0) && !m_target,
                      m_fault);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
